lif_neuron: RTL and testbench
=============================

LIF_NEURON -- requirements
Module: lif_neuron

Interface
REQ-001 Parameter N_IN, default 4: number of synaptic input channels (1..16).
REQ-002 Parameter W_WIDTH, default 4: unsigned synaptic weight magnitude width.
REQ-003 Parameter ACC_WIDTH, default 8: membrane potential and threshold width.
REQ-004 Parameter REF_CYCLES, default 2: refractory length in clock cycles (0..255).
REQ-005 Parameter LEAK_PERIOD, default 8: integrate-state cycles between leak decrements (>=1).
REQ-006 clk  in  1  single clock, all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 en  in  1  integrate/leak/fire enable; when low all state holds.
REQ-009 spike_in  in  N_IN  per-channel input pulse, one cycle per spike.
REQ-010 sign_in  in  N_IN  per-channel polarity, 1 = excitatory, 0 = inhibitory.
REQ-011 weight  in  N_IN*W_WIDTH  per-channel weight magnitude, channel i at bits [i*W_WIDTH +: W_WIDTH].
REQ-012 threshold  in  ACC_WIDTH  firing threshold; 0 disables firing.
REQ-013 leak_en  in  1  enables periodic leak.
REQ-014 out_sign_cfg  in  1  polarity driven on sign_out when firing.
REQ-015 spike_out  out  1  registered output pulse, exactly one cycle wide.
REQ-016 sign_out  out  1  output polarity, equals out_sign_cfg during spike_out, else 0.
REQ-017 potential  out  ACC_WIDTH  current membrane potential register.
REQ-018 refractory  out  1  high while in REFRACTORY state.

Function
REQ-019 State machine has two states, INTEGRATE and REFRACTORY; REFRACTORY is entered only by firing.
REQ-020 In INTEGRATE with en=1, delta = sum of weight[i] over channels with spike_in[i]=1 and sign_in[i]=1, minus sum over spike_in[i]=1 and sign_in[i]=0, computed at full signed width ACC_WIDTH+clog2(N_IN)+W_WIDTH+1 without overflow.
REQ-021 Leak applied first: leaked = potential-1 when leak tick occurs and potential>0, else potential.
REQ-022 next = leaked + delta, saturated to [0, 2^ACC_WIDTH-1]; no wrap-around in either direction.
REQ-023 Fire condition: INTEGRATE, en=1, threshold!=0, next >= threshold.
REQ-024 On fire: potential <= 0, spike_out <= 1 and sign_out <= out_sign_cfg on the following cycle, state <= REFRACTORY with counter REF_CYCLES; if REF_CYCLES=0 state stays INTEGRATE.
REQ-025 Otherwise in INTEGRATE with en=1: potential <= next, spike_out <= 0, sign_out <= 0.
REQ-026 Latency: input spike at edge k reflected in potential after edge k; resulting spike_out high for the cycle after edge k.
REQ-027 In REFRACTORY with en=1: inputs and leak ignored, potential held at 0, counter decrements each cycle, return to INTEGRATE on the edge where counter reaches 0 (exactly REF_CYCLES cycles of refractory=1).
REQ-028 Leak tick counter counts enabled INTEGRATE cycles with leak_en=1, ticks on every LEAK_PERIOD-th, then restarts; cleared on fire and when leak_en=0.
REQ-029 en=0: potential, state, refractory counter, leak counter hold; spike_out and sign_out forced to 0.
REQ-030 Simultaneous excitatory and inhibitory spikes net within the same cycle before saturation.
REQ-031 threshold change takes effect on the next evaluated cycle; lowering threshold below current potential fires on next enabled INTEGRATE cycle even with no input.

Reset
REQ-032 rst=1 at a rising edge sets potential=0, spike_out=0, sign_out=0, refractory=0, state=INTEGRATE, refractory and leak counters=0, overriding en and all inputs.
REQ-033 rst asserted mid-refractory or in the same cycle as a fire condition suppresses the spike; no pulse emitted after rst.

Verification
REQ-034 Defaults, threshold=10, weight ch0=4 excitatory, 3 spikes on consecutive cycles -> potential 4, 8, then 0 with spike_out=1 one cycle, refractory=1 for 2 cycles.
REQ-035 potential=5, ch1 weight 7 inhibitory spike -> potential 0 (saturate low); potential=250, all 4 channels weight 15 excitatory, threshold=0 -> potential 255, no spike.
REQ-036 leak_en=1, potential=3, no input, threshold=10 -> potential decrements at cycles 8, 16, 24 to 0 and holds.
REQ-037 ch0 +9 and ch2 -4 in same cycle from potential 0, threshold=5 -> fires, sign_out=out_sign_cfg; spikes during following 2 refractory cycles -> potential stays 0.
REQ-038 Fire condition and rst=1 on same edge -> spike_out stays 0, potential 0; en=0 for 5 cycles with spikes -> all state unchanged.

Source files
------------

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with signed synapses, periodic leak,
// saturating membrane potential and a refractory period after each spike.
module lif_neuron #(
  parameter int N_IN        = 4,
  parameter int W_WIDTH     = 4,
  parameter int ACC_WIDTH   = 8,
  parameter int REF_CYCLES  = 2,
  parameter int LEAK_PERIOD = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [N_IN-1:0]           spike_in,
  input  logic [N_IN-1:0]           sign_in,
  input  logic [N_IN*W_WIDTH-1:0]   weight,
  input  logic [ACC_WIDTH-1:0]      threshold,
  input  logic                      leak_en,
  input  logic                      out_sign_cfg,
  output logic                      spike_out,
  output logic                      sign_out,
  output logic [ACC_WIDTH-1:0]      potential,
  output logic                      refractory
);

  localparam int DW  = ACC_WIDTH + $clog2(N_IN) + W_WIDTH + 1;
  localparam int LCW = $clog2(LEAK_PERIOD + 1);

  localparam logic [0:0] S_INT = 1'b0;
  localparam logic [0:0] S_REF = 1'b1;

  localparam logic signed [DW-1:0] POT_MAX =
    $signed({{(DW-ACC_WIDTH){1'b0}}, {ACC_WIDTH{1'b1}}});

  logic [0:0]           state_q, state_d;
  logic [ACC_WIDTH-1:0] pot_q, pot_d;
  logic [7:0]           ref_q, ref_d;
  logic [LCW-1:0]       leak_q, leak_d;
  logic                 spike_q, spike_d;
  logic                 sign_q, sign_d;

  logic signed [DW-1:0] delta;
  logic signed [DW-1:0] sum;
  logic [ACC_WIDTH-1:0] leaked;
  logic [ACC_WIDTH-1:0] nxt;
  logic                 leak_tick;
  logic                 fire;

  always_comb begin
    delta = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (spike_in[i]) begin
        if (sign_in[i])
          delta = delta + $signed({{(DW-W_WIDTH){1'b0}},
                                   weight[i*W_WIDTH +: W_WIDTH]});
        else
          delta = delta - $signed({{(DW-W_WIDTH){1'b0}},
                                   weight[i*W_WIDTH +: W_WIDTH]});
      end
    end
  end

  // Leak is taken before the synaptic delta, then the sum saturates.
  always_comb begin
    leak_tick = leak_en && (leak_q == LCW'(LEAK_PERIOD - 1));
    leaked    = (leak_tick && pot_q != '0) ? pot_q - 1'b1 : pot_q;
    sum       = $signed({{(DW-ACC_WIDTH){1'b0}}, leaked}) + delta;
    if (sum < 0)
      nxt = '0;
    else if (sum > POT_MAX)
      nxt = '1;
    else
      nxt = sum[ACC_WIDTH-1:0];
    fire = (state_q == S_INT) && en && (threshold != '0)
           && (nxt >= threshold);
  end

  always_comb begin
    state_d = state_q;
    pot_d   = pot_q;
    ref_d   = ref_q;
    leak_d  = leak_q;
    spike_d = 1'b0;
    sign_d  = 1'b0;
    if (en) begin
      unique case (state_q)
        S_INT: begin
          if (fire) begin
            pot_d   = '0;
            spike_d = 1'b1;
            sign_d  = out_sign_cfg;
            leak_d  = '0;
            if (REF_CYCLES != 0) begin
              state_d = S_REF;
              ref_d   = 8'(REF_CYCLES);
            end
          end else begin
            pot_d = nxt;
            if (!leak_en || leak_tick)
              leak_d = '0;
            else
              leak_d = leak_q + LCW'(1);
          end
        end
        S_REF: begin
          pot_d = '0;
          ref_d = ref_q - 8'd1;
          if (ref_q == 8'd1)
            state_d = S_INT;
        end
        default: state_d = S_INT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INT;
      pot_q   <= '0;
      ref_q   <= '0;
      leak_q  <= '0;
      spike_q <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pot_q   <= pot_d;
      ref_q   <= ref_d;
      leak_q  <= leak_d;
      spike_q <= spike_d;
      sign_q  <= sign_d;
    end
  end

  assign spike_out  = spike_q;
  assign sign_out   = sign_q;
  assign potential  = pot_q;
  assign refractory = (state_q == S_REF);

endmodule

// File: tb/tb_lif_neuron.sv
// Scoreboard bench for lif_neuron: stimulus pushes hand-computed
// per-cycle expectations, a monitor pops and compares after each edge.
module tb_lif_neuron;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  spike_in;
  logic [3:0]  sign_in;
  logic [15:0] weight;
  logic [7:0]  threshold;
  logic        leak_en;
  logic        out_sign_cfg;
  logic        spike_out;
  logic        sign_out;
  logic [7:0]  potential;
  logic        refractory;

  typedef struct {
    int         id;
    logic [7:0] pot;
    logic       spk;
    logic       sgn;
    logic       rf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   nstep  = 0;

  lif_neuron dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .spike_in     (spike_in),
    .sign_in      (sign_in),
    .weight       (weight),
    .threshold    (threshold),
    .leak_en      (leak_en),
    .out_sign_cfg (out_sign_cfg),
    .spike_out    (spike_out),
    .sign_out     (sign_out),
    .potential    (potential),
    .refractory   (refractory)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (potential !== e.pot) begin
        errors++;
        $display("FAIL step %0d potential got %0d want %0d",
                 e.id, potential, e.pot);
      end
      checks++;
      if (spike_out !== e.spk) begin
        errors++;
        $display("FAIL step %0d spike_out got %b want %b",
                 e.id, spike_out, e.spk);
      end
      checks++;
      if (sign_out !== e.sgn) begin
        errors++;
        $display("FAIL step %0d sign_out got %b want %b",
                 e.id, sign_out, e.sgn);
      end
      checks++;
      if (refractory !== e.rf) begin
        errors++;
        $display("FAIL step %0d refractory got %b want %b",
                 e.id, refractory, e.rf);
      end
    end
  end

  task automatic step(input logic [7:0] p, input logic s,
                      input logic g, input logic r);
    exp_t e;
    nstep++;
    e.id  = nstep;
    e.pot = p;
    e.spk = s;
    e.sgn = g;
    e.rf  = r;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    rst = 1; en = 1; spike_in = '0; sign_in = '0; weight = '0;
    threshold = '0; leak_en = 0; out_sign_cfg = 1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 0;

    // three +4 spikes against threshold 10
    threshold = 10; weight = 16'h0004; sign_in = 4'b0001;
    spike_in = 4'b0001;
    step(4, 0, 0, 0);
    step(8, 0, 0, 0);
    step(0, 1, 1, 1);
    spike_in = '0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // low saturation
    threshold = 0; weight = 16'h0005; spike_in = 4'b0001;
    step(5, 0, 0, 0);
    weight = 16'h0070; sign_in = 4'b0000; spike_in = 4'b0010;
    step(0, 0, 0, 0);

    // high saturation with firing disabled
    weight = 16'hFFFF; sign_in = 4'b1111; spike_in = 4'b1111;
    step(60, 0, 0, 0);
    step(120, 0, 0, 0);
    step(180, 0, 0, 0);
    step(240, 0, 0, 0);
    weight = 16'h000A; spike_in = 4'b0001;
    step(250, 0, 0, 0);
    weight = 16'hFFFF; spike_in = 4'b1111;
    step(255, 0, 0, 0);
    step(255, 0, 0, 0);

    // threshold lowered below potential fires without input
    spike_in = '0; threshold = 200; out_sign_cfg = 0;
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // leak: 3 -> 2 -> 1 -> 0 at enabled cycles 8, 16, 24
    threshold = 10; weight = 16'h0003; sign_in = 4'b0001;
    spike_in = 4'b0001; out_sign_cfg = 1;
    step(3, 0, 0, 0);
    spike_in = '0; leak_en = 1;
    for (int c = 1; c <= 30; c++) begin
      if (c < 8)       step(3, 0, 0, 0);
      else if (c < 16) step(2, 0, 0, 0);
      else if (c < 24) step(1, 0, 0, 0);
      else             step(0, 0, 0, 0);
    end
    leak_en = 0;

    // +9 and -4 net to 5 in one cycle, then spikes during refractory
    threshold = 5; weight = 16'h0409; sign_in = 4'b0001;
    spike_in = 4'b0101;
    step(0, 1, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    spike_in = '0;
    step(0, 0, 0, 0);

    // fire condition together with reset
    weight = 16'h0009; spike_in = 4'b0001; rst = 1;
    step(0, 0, 0, 0);
    rst = 0; threshold = 10; weight = 16'h0006;
    step(6, 0, 0, 0);

    // en low holds state despite spikes
    en = 0;
    for (int c = 0; c < 5; c++) step(6, 0, 0, 0);
    en = 1;
    step(0, 1, 1, 1);
    en = 0;
    for (int c = 0; c < 3; c++) step(0, 0, 0, 1);
    en = 1; spike_in = '0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // reset mid-refractory
    weight = 16'h000C; spike_in = 4'b0001;
    step(0, 1, 1, 1);
    rst = 1; spike_in = '0;
    step(0, 0, 0, 0);
    rst = 0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain got %0d left want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
